// File: rtl/ciccio_arbiter.sv
// ----------------------------------------------------------------------------
// ciccio_arbiter
// Two-requester round-robin arbiter and sequencer for the ciccio 2:1 select
// datapath. Grants the single output lane to one requester at a time in
// bursts. A burst ends on an accepted last beat, when the granted requester
// drops its request, or on a forced yield: MAX_BURST beats accepted while the
// other requester is waiting. A priority pointer breaks ties from IDLE and
// always points at the requester that did not hold the most recent grant.
//
// Parameters
//   MAX_BURST    beats per grant before yielding to a waiting requester (>=1)
//   CNT_W        width of io_beat_cnt, 2**CNT_W > MAX_BURST
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   synchronous active-low reset
//   io_req0/1      in   requester 0/1 wants the lane
//   io_in0/1       in   data bit of requester 0/1
//   io_last0/1     in   current beat of requester 0/1 ends its burst
//   io_out_ready   in   consumer accepts a beat this cycle
//   io_gnt0/1      out  registered grant, one-hot or both 0
//   io_sel         out  registered mux select (0 = in0, 1 = in1)
//   io_out         out  muxed data bit, combinational from io_sel and inputs
//   io_out_valid   out  granted requester's request, combinational
//   io_beat_cnt    out  beats accepted in the current grant, saturating
// ----------------------------------------------------------------------------
module ciccio_arbiter #(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             io_req0,
   input  logic             io_req1,
   input  logic             io_in0,
   input  logic             io_in1,
   input  logic             io_last0,
   input  logic             io_last1,
   input  logic             io_out_ready,
   output logic             io_gnt0,
   output logic             io_gnt1,
   output logic             io_sel,
   output logic             io_out,
   output logic             io_out_valid,
   output logic [CNT_W-1:0] io_beat_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

   // Saturating increment of the beat counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_W'(1);
      end
   endfunction

   state_t           state_r;
   state_t           next_state_s;
   logic             prio_r;
   logic             gnt0_r;
   logic             gnt1_r;
   logic             sel_r;
   logic [CNT_W-1:0] cnt_r;

   logic             cur_req_s;
   logic             oth_req_s;
   logic             cur_last_s;
   logic             cur_id_s;
   logic             granted_s;
   logic             fire_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             grant_end_s;

   // Views of the current grant holder and the other requester.
   always_comb begin
      cur_req_s  = 1'b0;
      oth_req_s  = 1'b0;
      cur_last_s = 1'b0;
      cur_id_s   = 1'b0;
      granted_s  = 1'b0;
      case (state_r)
         G0: begin
            cur_req_s  = io_req0;
            oth_req_s  = io_req1;
            cur_last_s = io_last0;
            cur_id_s   = 1'b0;
            granted_s  = 1'b1;
         end
         G1: begin
            cur_req_s  = io_req1;
            oth_req_s  = io_req0;
            cur_last_s = io_last1;
            cur_id_s   = 1'b1;
            granted_s  = 1'b1;
         end
         default: begin
            cur_req_s  = 1'b0;
            oth_req_s  = 1'b0;
            cur_last_s = 1'b0;
            cur_id_s   = 1'b0;
            granted_s  = 1'b0;
         end
      endcase
   end

   // Beat acceptance and end-of-grant detection.
   always_comb begin
      fire_s    = cur_req_s & io_out_ready;
      cnt_inc_s = sat_inc(cnt_r);
      // Release (request dropped) can never coincide with a fire since the
      // valid is the request itself.
      grant_end_s = granted_s &
                    ((fire_s & cur_last_s) |
                     (~cur_req_s) |
                     (fire_s & (cnt_inc_s == MAX_C) & oth_req_s));
   end

   // Next-state selection: from IDLE by request/priority, from a grant by
   // handing over to a waiting requester first, then a new own burst.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (io_req0 && io_req1) begin
               next_state_s = prio_r ? G1 : G0;
            end else if (io_req0) begin
               next_state_s = G0;
            end else if (io_req1) begin
               next_state_s = G1;
            end else begin
               next_state_s = IDLE;
            end
         end
         G0, G1: begin
            if (!grant_end_s) begin
               next_state_s = state_r;
            end else if (oth_req_s) begin
               next_state_s = (state_r == G0) ? G1 : G0;
            end else if (cur_req_s) begin
               next_state_s = state_r;
            end else begin
               next_state_s = IDLE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Arbiter FSM with registered grant, select, priority and beat count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= IDLE;
         prio_r  <= 1'b0;
         gnt0_r  <= 1'b0;
         gnt1_r  <= 1'b0;
         sel_r   <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= next_state_s;
         gnt0_r  <= (next_state_s == G0);
         gnt1_r  <= (next_state_s == G1);
         // Select follows the grant; in IDLE it keeps its last value.
         if (next_state_s == G0) begin
            sel_r <= 1'b0;
         end else if (next_state_s == G1) begin
            sel_r <= 1'b1;
         end else begin
            sel_r <= sel_r;
         end
         if (grant_end_s) begin
            prio_r <= ~cur_id_s;
            cnt_r  <= {CNT_W{1'b0}};
         end else if (fire_s) begin
            prio_r <= prio_r;
            cnt_r  <= cnt_inc_s;
         end else begin
            prio_r <= prio_r;
            cnt_r  <= cnt_r;
         end
      end
   end

   assign io_gnt0      = gnt0_r;
   assign io_gnt1      = gnt1_r;
   assign io_sel       = sel_r;
   assign io_beat_cnt  = cnt_r;
   assign io_out_valid = cur_req_s;
   assign io_out       = sel_r ? io_in1 : io_in0;

endmodule

// File: tb/tb_ciccio_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ciccio_arbiter
// Directed bench for ciccio_arbiter (MAX_BURST=4, CNT_W=3). Each cycle the
// stimulus is applied together with the hand-derived expected outputs for
// that cycle; the expectation is queued and then popped and compared.
// ----------------------------------------------------------------------------
module tb_ciccio_arbiter;

   logic       clk;
   logic       reset;
   logic       io_req0;
   logic       io_req1;
   logic       io_in0;
   logic       io_in1;
   logic       io_last0;
   logic       io_last1;
   logic       io_out_ready;
   logic       io_gnt0;
   logic       io_gnt1;
   logic       io_sel;
   logic       io_out;
   logic       io_out_valid;
   logic [2:0] io_beat_cnt;

   typedef struct packed {
      logic       g0;
      logic       g1;
      logic       sel;
      logic       valid;
      logic       out;
      logic [2:0] cnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   ciccio_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .io_req0      (io_req0),
      .io_req1      (io_req1),
      .io_in0       (io_in0),
      .io_in1       (io_in1),
      .io_last0     (io_last0),
      .io_last1     (io_last1),
      .io_out_ready (io_out_ready),
      .io_gnt0      (io_gnt0),
      .io_gnt1      (io_gnt1),
      .io_sel       (io_sel),
      .io_out       (io_out),
      .io_out_valid (io_out_valid),
      .io_beat_cnt  (io_beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle: apply inputs just after the edge, queue the expectation for
   // this cycle, then pop it and compare mid-cycle.
   task automatic cyc(input string tag,
                      input logic r0, input logic r1,
                      input logic l0, input logic l1,
                      input logic rdy, input logic i0, input logic i1,
                      input logic eg0, input logic eg1, input logic esel,
                      input logic [2:0] ecnt);
      exp_t e;
      exp_t got;
      @(posedge clk);
      #1;
      io_req0 = r0; io_req1 = r1; io_last0 = l0; io_last1 = l1;
      io_out_ready = rdy; io_in0 = i0; io_in1 = i1;
      e.g0    = eg0;
      e.g1    = eg1;
      e.sel   = esel;
      e.valid = eg0 ? r0 : (eg1 ? r1 : 1'b0);
      e.out   = esel ? i1 : i0;
      e.cnt   = ecnt;
      q.push_back(e);
      #1;
      got = q.pop_front();
      checks++;
      assert (io_gnt0 === got.g0) else begin
         errors++;
         $error("FAIL %s gnt0: observed %b expected %b", tag, io_gnt0, got.g0);
      end
      checks++;
      assert (io_gnt1 === got.g1) else begin
         errors++;
         $error("FAIL %s gnt1: observed %b expected %b", tag, io_gnt1, got.g1);
      end
      checks++;
      assert (io_sel === got.sel) else begin
         errors++;
         $error("FAIL %s sel: observed %b expected %b", tag, io_sel, got.sel);
      end
      checks++;
      assert (io_out_valid === got.valid) else begin
         errors++;
         $error("FAIL %s valid: observed %b expected %b", tag, io_out_valid, got.valid);
      end
      checks++;
      assert (io_out === got.out) else begin
         errors++;
         $error("FAIL %s out: observed %b expected %b", tag, io_out, got.out);
      end
      checks++;
      assert (io_beat_cnt === got.cnt) else begin
         errors++;
         $error("FAIL %s cnt: observed %0d expected %0d", tag, io_beat_cnt, got.cnt);
      end
   endtask

   initial begin
      reset = 1'b0;
      io_req0 = 1'b0; io_req1 = 1'b0; io_last0 = 1'b0; io_last1 = 1'b0;
      io_out_ready = 1'b0; io_in0 = 1'b0; io_in1 = 1'b0;

      // Reset state.
      cyc("rst",   0,0,0,0,0,0,0, 0,0,0,3'd0);
      reset = 1'b1;
      cyc("idle",  0,0,0,0,0,0,0, 0,0,0,3'd0);

      // Single burst from requester 0, last on beat 3, then a release.
      cyc("req0",  1,0,0,0,1,1,0, 0,0,0,3'd0);
      cyc("b1",    1,0,0,0,1,0,1, 1,0,0,3'd0);
      cyc("b2",    1,0,0,0,1,1,0, 1,0,0,3'd1);
      cyc("b3",    1,0,1,0,1,0,1, 1,0,0,3'd2);
      cyc("rel0",  0,0,0,0,1,1,0, 1,0,0,3'd0);
      cyc("idle2", 0,0,0,0,0,0,1, 0,0,0,3'd0);

      // Both request from IDLE: priority now points at requester 1.
      cyc("both",  1,1,0,0,0,1,0, 0,0,0,3'd0);

      // Continuous contention: G1 x4, G0 x4, G1 x4 with no bubble.
      for (int b = 0; b < 12; b++) begin
         logic g0e;
         g0e = (((b / 4) % 2) == 1);
         cyc("alt", 1,1,0,0,1, b[0], ~b[0], g0e, ~g0e, ~g0e, 3'(b % 4));
      end

      // Requester 0 releases with requester 1 waiting: immediate handover.
      cyc("rel_ho", 0,1,0,0,1,0,1, 1,0,0,3'd0);
      cyc("g1b1",   0,1,0,0,1,1,0, 0,1,1,3'd0);

      // Stall on beat 2 of G1; last during a stall is ignored.
      for (int s = 0; s < 5; s++) begin
         cyc("stall", 0,1,0,1,0, s[0], ~s[0], 0,1,1,3'd1);
      end
      cyc("g1b2",  0,1,0,1,1,0,1, 0,1,1,3'd1);
      cyc("g1nb",  0,1,0,0,1,1,0, 0,1,1,3'd0);
      cyc("g1nb2", 0,1,0,0,1,0,1, 0,1,1,3'd1);

      // Reset for one edge in the middle of a G1 burst.
      reset = 1'b0;
      cyc("mrst",  0,1,0,0,1,1,1, 0,0,0,3'd0);
      reset = 1'b1;
      // G1 re-granted one cycle after reset deasserts; release to G0.
      cyc("regnt", 1,0,0,0,1,0,1, 0,1,1,3'd0);

      // Requester 0 alone: no forced yield, counter saturates at 7.
      for (int b = 0; b < 9; b++) begin
         cyc("solo", 1,0,0,0,1, b[1], b[0], 1,0,0, (b > 7) ? 3'd7 : 3'(b));
      end
      cyc("solo_rel", 0,0,0,0,1,1,0, 1,0,0,3'd7);

      // io_sel holds its last value in IDLE.
      cyc("r1",     0,1,0,0,0,0,0, 0,0,0,3'd0);
      cyc("r1g",    0,0,0,0,1,0,1, 0,1,1,3'd0);
      cyc("holdsel",0,0,0,0,0,1,0, 0,0,1,3'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ciccio_arbiter.md
# ciccio_arbiter

Two-requester round-robin arbiter and sequencer for the `ciccio` 2:1 select datapath. It owns `io_sel` of the shared mux and grants the single output lane to one requester at a time, in bursts ended by a last flag, by a requester dropping its request, or by a maximum-burst limit. Fairness is enforced by a priority pointer and a forced yield. It sits between two bit-serial producers and one consumer that may apply backpressure.

## Interface
- `MAX_BURST`, default 4: maximum beats in one grant while the other requester waits; legal range ≥1.
- `CNT_W`, default 3: width of `io_beat_cnt`; must satisfy 2^CNT_W > MAX_BURST.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on `clk`.
- `io_req0` / `io_req1`  in  1  requester 0/1 wants the lane.
- `io_in0` / `io_in1`  in  1  data bit of requester 0/1.
- `io_last0` / `io_last1`  in  1  current beat of requester 0/1 is the last of its burst.
- `io_out_ready`  in  1  consumer accepts a beat this cycle.
- `io_gnt0` / `io_gnt1`  out  1  registered grant; one-hot or both 0.
- `io_sel`  out  1  registered mux select, 0 = in0, 1 = in1.
- `io_out`  out  1  muxed data: `io_sel` ? `io_in1` : `io_in0`.
- `io_out_valid`  out  1  granted requester's `io_req` while granted.
- `io_beat_cnt`  out  CNT_W  beats accepted in the current grant.

## Operation
- States: IDLE, G0, G1. `io_gnt0` = (state==G0), `io_gnt1` = (state==G1).
- Priority pointer `prio` selects the winner when both request. Reset value 0.
- Beat accepted ("fire") = `io_out_valid` & `io_out_ready`. `io_beat_cnt` increments on fire and saturates at 2^CNT_W−1.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: go to that requester's grant state.
  - Both request: go to G`prio`.
- Gn, grant ends at the clock edge when any of these hold:
  - (a) fire with `io_lastn`=1;
  - (b) `io_reqn`=0, a release with no beat transferred that cycle;
  - (c) fire where the post-increment count == MAX_BURST and the other requester's `io_req`=1, a forced yield.
- End-of-grant next state:
  - G(other) if the other requester is requesting;
  - else Gn if `io_reqn`=1, as a new burst;
  - else IDLE.
- On any grant end:
  - `prio` ← other requester;
  - `io_beat_cnt` ← 0.
- Count reaching MAX_BURST with the other requester idle: no yield; the burst continues until last or release.
- `io_sel` ← n on every entry to Gn. It holds its value in IDLE.
- `io_out` is combinational from `io_sel` and the inputs at all times, valid or not.
- Reset (`reset`=0 at an edge), including mid-burst:
  - state ← IDLE, `prio` ← 0, `io_sel` ← 0, `io_beat_cnt` ← 0;
  - hence `io_gnt0`=`io_gnt1`=0 and `io_out_valid`=0 from the next cycle;
  - the in-flight burst is abandoned and no beat is reported.

## Timing
- Request latency: `io_req` asserted in cycle t while in IDLE → grant and `io_sel` visible in cycle t+1. First fire possible in t+1.
- Handover is zero-bubble: the end-of-grant edge at the end of cycle t moves the grant to the other requester in t+1.
- Back-to-back bursts from the same requester also take no idle cycle.
- `io_out_ready`=0 stalls: the count, state and `prio` hold unless a release (b) occurs.
- `io_last` and `io_in` are sampled only in fire cycles. `io_last` in a non-fire cycle is ignored.
- `io_out_valid` and `io_out` are combinational paths from the inputs. All other outputs are registered.

## Test plan
- Reset, then req0=1 with ready=1 for 3 beats, last on beat 3:
  - gnt0 rises 1 cycle after req0;
  - `io_beat_cnt` reads 0,1,2 during beats 1–3 and 0 after;
  - returns to IDLE when req0 drops.
- Both requesting continuously, last never set, MAX_BURST=4, ready=1:
  - grants alternate G0×4, G1×4, G0×4…;
  - no idle cycle at handover;
  - `io_sel` toggles with the grant.
- Both requesting from IDLE after a G0 burst ended: G1 wins (prio=1).
- During G1 beat 2, drive ready=0 for 5 cycles:
  - state and `io_beat_cnt`=1 hold;
  - `io_out` tracks `io_in1` throughout.
- req0 only, running 6 beats with no last, MAX_BURST=4: no forced yield; `io_beat_cnt` reaches 5 (CNT_W=3).
- Assert reset=0 for one cycle during G1 beat 2:
  - next cycle gnt0=gnt1=0, `io_sel`=0, count=0;
  - with req1 still high, G1 is re-granted one cycle after reset deasserts.
